// File: rtl/key_conditioner.sv
// Pushbutton and slide-switch conditioner: two-flop synchronisers, per-key debounce,
// press/release events, long-press detection and optional auto-repeat.
module key_conditioner #(
  parameter int NUM_KEYS          = 5,
  parameter int NUM_SW            = 8,
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int REPEAT_CYCLES     = 10000000,
  parameter bit ACTIVE_LOW        = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_raw,
  input  logic [NUM_SW-1:0]   sw_raw,
  input  logic [NUM_KEYS-1:0] repeat_en,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] long_pulse,
  output logic [NUM_KEYS-1:0] repeat_pulse,
  output logic [NUM_SW-1:0]   sw_sync
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, LONG} hold_state_t;

  logic [NUM_KEYS-1:0] key_meta;
  logic [NUM_KEYS-1:0] key_sync;
  logic [NUM_SW-1:0]   sw_meta;

  // Polarity is folded in ahead of the first flop, so a cleared flop always means "not pressed".
  always_ff @(posedge clk) begin
    if (rst) begin
      key_meta <= '0;
      key_sync <= '0;
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      key_meta <= key_raw ^ {NUM_KEYS{ACTIVE_LOW}};
      key_sync <= key_meta;
      sw_meta  <= sw_raw;
      sw_sync  <= sw_meta;
    end
  end

  genvar k;
  for (k = 0; k < NUM_KEYS; k++) begin : g_key
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [REP_W-1:0]  rep_cnt;
    hold_state_t       state;
    logic              level;
    logic              press;
    logic              rel;
    logic              lng;
    logic              rep;

    // A debounced flip takes priority over the hold FSM, so the release cycle never carries long/repeat.
    always_ff @(posedge clk) begin
      if (rst) begin
        db_cnt   <= '0;
        hold_cnt <= '0;
        rep_cnt  <= '0;
        state    <= IDLE;
        level    <= 1'b0;
        press    <= 1'b0;
        rel      <= 1'b0;
        lng      <= 1'b0;
        rep      <= 1'b0;
      end else begin
        press <= 1'b0;
        rel   <= 1'b0;
        lng   <= 1'b0;
        rep   <= 1'b0;
        if ((key_sync[k] != level) && (db_cnt == DB_LAST)) begin
          db_cnt   <= '0;
          level    <= key_sync[k];
          hold_cnt <= '0;
          rep_cnt  <= '0;
          if (key_sync[k]) begin
            press <= 1'b1;
            state <= HOLD;
          end else begin
            rel   <= 1'b1;
            state <= IDLE;
          end
        end else begin
          if (key_sync[k] != level) begin
            db_cnt <= db_cnt + 1'b1;
          end else begin
            db_cnt <= '0;
          end
          case (state)
            HOLD: begin
              if (hold_cnt == HOLD_LAST) begin
                state    <= LONG;
                hold_cnt <= HOLD_MAX;
                lng      <= 1'b1;
                rep      <= repeat_en[k];
                rep_cnt  <= '0;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
            LONG: begin
              if (!repeat_en[k]) begin
                rep_cnt <= '0;
              end else if (rep_cnt == REP_LAST) begin
                rep     <= 1'b1;
                rep_cnt <= '0;
              end else begin
                rep_cnt <= rep_cnt + 1'b1;
              end
            end
            default: begin
            end
          endcase
        end
      end
    end

    assign key_level[k]     = level;
    assign press_pulse[k]   = press;
    assign release_pulse[k] = rel;
    assign long_pulse[k]    = lng;
    assign repeat_pulse[k]  = rep;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: one active-high and one active-low instance,
// expected pulse events queued by stimulus and popped by a monitor whenever any pulse appears.
module tb_key_conditioner;

  localparam int NK = 3;
  localparam int NS = 8;

  typedef struct {
    int         cyc;
    logic [2:0] press;
    logic [2:0] rel;
    logic [2:0] lng;
    logic [2:0] rep;
  } ev_t;

  logic          clk;
  logic          rst;
  logic [NK-1:0] key_raw_a, key_raw_b;
  logic [NK-1:0] repeat_en_a, repeat_en_b;
  logic [NS-1:0] sw_raw;
  logic [NK-1:0] level_a, press_a, rel_a, long_a, rep_a;
  logic [NK-1:0] level_b, press_b, rel_b, long_b, rep_b;
  logic [NS-1:0] sw_a, sw_b;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   started = 0;
  ev_t  qa[$];
  ev_t  qb[$];
  ev_t  ea, eb;

  key_conditioner #(
    .NUM_KEYS(NK), .NUM_SW(NS), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(10),
    .REPEAT_CYCLES(3), .ACTIVE_LOW(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .key_raw(key_raw_a), .sw_raw(sw_raw), .repeat_en(repeat_en_a),
    .key_level(level_a), .press_pulse(press_a), .release_pulse(rel_a),
    .long_pulse(long_a), .repeat_pulse(rep_a), .sw_sync(sw_a)
  );

  key_conditioner #(
    .NUM_KEYS(NK), .NUM_SW(NS), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(10),
    .REPEAT_CYCLES(3), .ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .key_raw(key_raw_b), .sw_raw(sw_raw), .repeat_en(repeat_en_b),
    .key_level(level_b), .press_pulse(press_b), .release_pulse(rel_b),
    .long_pulse(long_b), .repeat_pulse(rep_b), .sw_sync(sw_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc counts rising edges; read at the falling edge it names the cycle being observed
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic checkEvent(input string name, input ev_t e, input int now,
                            input logic [2:0] p, input logic [2:0] r,
                            input logic [2:0] l, input logic [2:0] rp);
    checks++;
    if (now != e.cyc || p !== e.press || r !== e.rel || l !== e.lng || rp !== e.rep) begin
      errors++;
      $display("[TB] FAIL %s: got cycle %0d press=%b rel=%b long=%b rep=%b expected cycle %0d press=%b rel=%b long=%b rep=%b",
               name, now, p, r, l, rp, e.cyc, e.press, e.rel, e.lng, e.rep);
    end
  endtask

  task automatic pushA(input int c, input logic [2:0] p, input logic [2:0] r,
                       input logic [2:0] l, input logic [2:0] rp);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.lng = l; e.rep = rp;
    qa.push_back(e);
  endtask

  task automatic pushB(input int c, input logic [2:0] p, input logic [2:0] r,
                       input logic [2:0] l, input logic [2:0] rp);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.lng = l; e.rep = rp;
    qb.push_back(e);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: any pulse on an instance consumes the next expected event for that instance
  always @(negedge clk) begin
    if (started && !rst) begin
      if (|{press_a, rel_a, long_a, rep_a}) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL ev_a unexpected at cycle %0d: press=%b rel=%b long=%b rep=%b expected no pulse",
                   cyc, press_a, rel_a, long_a, rep_a);
        end else begin
          ea = qa.pop_front();
          checkEvent("ev_a", ea, cyc, press_a, rel_a, long_a, rep_a);
        end
      end
      if (|{press_b, rel_b, long_b, rep_b}) begin
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL ev_b unexpected at cycle %0d: press=%b rel=%b long=%b rep=%b expected no pulse",
                   cyc, press_b, rel_b, long_b, rep_b);
        end else begin
          eb = qb.pop_front();
          checkEvent("ev_b", eb, cyc, press_b, rel_b, long_b, rep_b);
        end
      end
    end
  end

  task automatic applyStimulus();
    int c;
    int r;

    // reset state
    checkOutput("rst_a", {level_a, press_a, rel_a, long_a, rep_a, sw_a}, 32'h0);
    checkOutput("rst_b", {level_b, press_b, rel_b, long_b, rep_b, sw_b}, 32'h0);
    rst = 1'b0;
    started = 1'b1;
    waitCycles(2);
    checkOutput("idle_a", {level_a, press_a, rel_a, long_a, rep_a}, 32'h0);
    checkOutput("idle_b", {level_b, press_b, rel_b, long_b, rep_b}, 32'h0);

    // clean press and release of key0, no long press
    c = cyc;
    key_raw_a[0] = 1'b1;
    pushA(c + 6, 3'b001, 3'b000, 3'b000, 3'b000);
    waitCycles(4);
    checkOutput("s1_level_early", 32'(level_a), 32'h0);
    waitCycles(4);
    checkOutput("s1_level_held", 32'(level_a), 32'h1);
    key_raw_a[0] = 1'b0;
    pushA(c + 14, 3'b000, 3'b001, 3'b000, 3'b000);
    waitCycles(12);
    checkOutput("s1_level_after", 32'(level_a), 32'h0);

    // bounce on key1: 3 high, 2 low, never long enough to flip
    for (int i = 0; i < 8; i++) begin
      key_raw_a[1] = 1'b1;
      for (int j = 0; j < 3; j++) begin
        waitCycles(1);
        checkOutput("s2_bounce_level", 32'(level_a[1]), 32'h0);
      end
      key_raw_a[1] = 1'b0;
      for (int j = 0; j < 2; j++) begin
        waitCycles(1);
        checkOutput("s2_bounce_level", 32'(level_a[1]), 32'h0);
      end
    end
    waitCycles(8);

    // long hold on key2 with auto-repeat; the repeat due on the release cycle is suppressed
    repeat_en_a = 3'b100;
    c = cyc;
    key_raw_a[2] = 1'b1;
    pushA(c + 6,  3'b100, 3'b000, 3'b000, 3'b000);
    pushA(c + 16, 3'b000, 3'b000, 3'b100, 3'b100);
    pushA(c + 19, 3'b000, 3'b000, 3'b000, 3'b100);
    pushA(c + 22, 3'b000, 3'b000, 3'b000, 3'b100);
    pushA(c + 25, 3'b000, 3'b000, 3'b000, 3'b100);
    pushA(c + 28, 3'b000, 3'b000, 3'b000, 3'b100);
    waitCycles(25);
    checkOutput("s3_level_held", 32'(level_a), 32'h4);
    key_raw_a[2] = 1'b0;
    pushA(c + 31, 3'b000, 3'b100, 3'b000, 3'b000);
    waitCycles(10);

    // same hold without auto-repeat
    repeat_en_a = 3'b000;
    c = cyc;
    key_raw_a[2] = 1'b1;
    pushA(c + 6,  3'b100, 3'b000, 3'b000, 3'b000);
    pushA(c + 16, 3'b000, 3'b000, 3'b100, 3'b000);
    waitCycles(25);
    key_raw_a[2] = 1'b0;
    pushA(c + 31, 3'b000, 3'b100, 3'b000, 3'b000);
    waitCycles(10);

    // active-low instance: key0 held through reset re-presses, no release for the interrupted press
    c = cyc;
    key_raw_b[0] = 1'b0;
    pushB(c + 6, 3'b001, 3'b000, 3'b000, 3'b000);
    waitCycles(10);
    checkOutput("s5_level_b", 32'(level_b), 32'h1);
    rst = 1'b1;
    waitCycles(1);
    checkOutput("s5_rst_b", {level_b, press_b, rel_b, long_b, rep_b}, 32'h0);
    waitCycles(1);
    rst = 1'b0;
    r = cyc;
    pushB(r + 6, 3'b001, 3'b000, 3'b000, 3'b000);
    waitCycles(6);
    checkOutput("s5_repress_b", 32'(press_b), 32'h1);
    waitCycles(2);
    key_raw_b[0] = 1'b1;
    pushB(r + 14, 3'b000, 3'b001, 3'b000, 3'b000);
    waitCycles(10);

    // keys 0 and 2 pressed together on the active-low instance
    c = cyc;
    key_raw_b = 3'b010;
    pushB(c + 6, 3'b101, 3'b000, 3'b000, 3'b000);
    waitCycles(8);
    checkOutput("s5_level_pair", 32'(level_b), 32'h5);
    key_raw_b = 3'b111;
    pushB(c + 14, 3'b000, 3'b101, 3'b000, 3'b000);
    waitCycles(10);

    // switch synchroniser latency
    sw_raw = 8'hA5;
    waitCycles(1);
    checkOutput("s6_sw_1cyc", 32'(sw_a), 32'h00);
    waitCycles(1);
    checkOutput("s6_sw_2cyc_a", 32'(sw_a), 32'hA5);
    checkOutput("s6_sw_2cyc_b", 32'(sw_b), 32'hA5);

    // reset in the middle of a key1 hold
    c = cyc;
    key_raw_a[1] = 1'b1;
    pushA(c + 6, 3'b010, 3'b000, 3'b000, 3'b000);
    waitCycles(10);
    rst = 1'b1;
    waitCycles(1);
    checkOutput("s6_rst_a", {level_a, press_a, rel_a, long_a, rep_a, sw_a}, 32'h0);
    checkOutput("s6_rst_b", {level_b, sw_b}, 32'h0);
    waitCycles(1);
    rst = 1'b0;
    r = cyc;
    pushA(r + 6, 3'b010, 3'b000, 3'b000, 3'b000);
    waitCycles(8);
    checkOutput("s6_sw_after_rst", 32'(sw_a), 32'hA5);
    key_raw_a[1] = 1'b0;
    pushA(r + 14, 3'b000, 3'b010, 3'b000, 3'b000);
    waitCycles(12);
  endtask

  initial begin
    rst = 1'b1;
    key_raw_a = '0;
    key_raw_b = '1;
    repeat_en_a = '0;
    repeat_en_b = '0;
    sw_raw = '0;
    waitCycles(3);
    applyStimulus();

    for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) waitCycles(1);
    while (qa.size() != 0) begin
      ea = qa.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL ev_a missing: got no pulse expected cycle %0d press=%b rel=%b long=%b rep=%b",
               ea.cyc, ea.press, ea.rel, ea.lng, ea.rep);
    end
    while (qb.size() != 0) begin
      eb = qb.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL ev_b missing: got no pulse expected cycle %0d press=%b rel=%b long=%b rep=%b",
               eb.cyc, eb.press, eb.rel, eb.lng, eb.rep);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Parametrised input-conditioning block for the board's pushbuttons and slide switches. It synchronises every raw input into `clk`, debounces each key independently, and emits one-cycle press and release events. It also detects long presses and generates auto-repeat events for keys that enable it. It sits between the board pins and `ctrl_fsm` and replaces the fixed 5-key, press-only debounce logic with a configurable channel count and polarity.

## Interface
- `NUM_KEYS`, default 5: number of key channels, ≥1.
- `NUM_SW`, default 8: number of switch channels, ≥1.
- `DEBOUNCE_CYCLES`, default 1000000: consecutive mismatched cycles required before the debounced level flips. 20 ms at 50 MHz. ≥1.
- `LONG_PRESS_CYCLES`, default 50000000: hold time before `long_pulse` fires. 1 s at 50 MHz. ≥1.
- `REPEAT_CYCLES`, default 10000000: auto-repeat period. 200 ms at 50 MHz. ≥1.
- `ACTIVE_LOW`, default 0: 1 means a raw key level of 0 is "pressed".
- `clk` in 1: system clock. One clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `key_raw` in NUM_KEYS: asynchronous raw key pins.
- `sw_raw` in NUM_SW: asynchronous raw switch pins.
- `repeat_en` in NUM_KEYS: per-key auto-repeat enable, sampled every cycle.
- `key_level` out NUM_KEYS: debounced logical level (1 = pressed).
- `press_pulse` out NUM_KEYS: one-cycle pulse on each debounced press.
- `release_pulse` out NUM_KEYS: one-cycle pulse on each debounced release.
- `long_pulse` out NUM_KEYS: one-cycle pulse, at most once per press.
- `repeat_pulse` out NUM_KEYS: one-cycle auto-repeat pulses.
- `sw_sync` out NUM_SW: two-flop-synchronised switch levels. No debounce is applied.

## Operation
**Synchronisers**
- Every `key_raw` and `sw_raw` bit passes through two flops.
- Key bits are XORed with `ACTIVE_LOW` before the first flop, so all internal logic is active-high.

**Per-key debounce**
- The debounce counter is `$clog2(DEBOUNCE_CYCLES+1)` bits wide.
- When the synced bit differs from `key_level`, the counter increments.
- On the DEBOUNCE_CYCLES-th consecutive mismatched cycle, `key_level` takes the synced value and the counter clears.
- Any cycle where the two match clears the counter. A glitch shorter than DEBOUNCE_CYCLES therefore never reaches `key_level`.

**Event generation**
- `press_pulse` and `release_pulse` are asserted in the same cycle that `key_level` first shows the new value, for exactly one cycle.

**Per-key hold state machine (IDLE / HOLD / LONG)**
- IDLE → HOLD on a press; the hold counter is cleared to 0.
- In HOLD, the hold counter increments each cycle while `key_level`=1.
- HOLD → LONG when the counter reaches LONG_PRESS_CYCLES. `long_pulse` fires in that cycle.
- If `repeat_en` is 1 in that cycle, `repeat_pulse` fires too, and a repeat counter is cleared.
- In LONG with `repeat_en`=1, `repeat_pulse` fires every REPEAT_CYCLES cycles.
- Deasserting `repeat_en` in LONG suppresses pulses and holds the repeat counter at 0. Reasserting it restarts the REPEAT_CYCLES period from 0, with no immediate pulse.
- Any state → IDLE on release. The release cycle itself never carries `long_pulse` or `repeat_pulse`.

**Channel independence**
- All channels are fully independent.
- Simultaneous events on several keys produce simultaneous pulses on their bits.

## Timing
**Reset** (synchronous, dominates all other logic):
- All synchroniser flops are cleared to the logical-inactive value. For keys this is raw 0 when `ACTIVE_LOW`=0, raw 1 when `ACTIVE_LOW`=1. For switches it is 0.
- All counters = 0 and all state machines = IDLE.
- All outputs read 0 in the first cycle after reset.

**Press latency**
- A raw edge is first sampled at edge E0. `key_level` and `press_pulse` are high after edge E0+1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 cycles.
- Release latency is identical.

**Long press and repeat**
- Let P be the `press_pulse` cycle. `long_pulse` fires in cycle P+LONG_PRESS_CYCLES.
- Repeats fire at P+LONG_PRESS_CYCLES+n·REPEAT_CYCLES, for n ≥ 0, while the key is held and `repeat_en`=1.

**Switches**
- `sw_sync` latency is 2 cycles.

**Reset mid-operation**
- A key held through reset produces a fresh `press_pulse` DEBOUNCE_CYCLES+2 cycles after `rst` falls.
- No `release_pulse` is emitted for the interrupted press.

**Saturation**
- The hold and repeat counters never wrap. The hold counter stops at LONG_PRESS_CYCLES.

## Test plan
Bench parameters for all scenarios: NUM_KEYS=3, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, REPEAT_CYCLES=3.
1. Clean press of key0 at E0, held for 8 cycles, then released → `press_pulse[0]` high only in cycle E0+5. Clean release behaves symmetrically. No `long_pulse`.
2. Bounce: key1 toggles with 3-cycle highs and 2-cycle lows for 40 cycles → `key_level[1]` stays 0 and no pulses occur.
3. Long hold on key2 with `repeat_en[2]`=1, held 25 cycles after `press_pulse` at P → `long_pulse` and `repeat_pulse` at P+10. Repeats follow at P+13, P+16, …, P+22, with no pulses on release.
4. Same as scenario 3 with `repeat_en[2]`=0 → single `long_pulse` at P+10 and no `repeat_pulse`.
5. `ACTIVE_LOW`=1, with `rst` asserted while key0's raw level is 0 → after `rst` falls, `press_pulse[0]` fires 6 cycles later. Keys 0 and 2 pressed in the same cycle produce pulses in the same cycle.
6. `sw_raw` changes from 0x00 to 0xA5 → `sw_sync` = 0xA5 exactly 2 cycles later. `rst` asserted mid-hold clears all outputs the next cycle.
